gbt_link_sequencer: RTL

- Bring-up and supervision controller for the GBT optical link in the 40 MHz frame-clock domain.
- Inputs: SFP LOS and GBT core status (link_ready, RX header flag).
- Sequences GBT core reset, releases bitslip alignment, qualifies the link on consecutive good headers, gates TX payload, and retries with backoff on timeout or error bursts.
- Sits between the SFP/diag pins and the GBT transceiver instance; replaces the ad-hoc bitslip_reset logic in the top level.

---
 rtl/gbt_seq_pkg.sv | 23 ++
 rtl/gbt_los_debounce.sv | 64 ++++++
 rtl/gbt_link_sequencer.sv | 159 +++++++++++++++
 3 files changed

// File: rtl/gbt_seq_pkg.sv
// Shared types and constants for the GBT link bring-up sequencer.
//   ckrs_t          : clock/reset bundle (clk, synchronous active-high reset)
//   gbt_seq_state_t : sequencer state encoding, also exported on state_o
//   DEBOUNCE_CYCLES : stability window of the optional LOS filter
package gbt_seq_pkg;

   typedef struct packed {
      logic clk;
      logic reset;
   } ckrs_t;

   typedef enum logic [2:0] {
      LOS      = 3'd0,
      RST      = 3'd1,
      WAIT_RDY = 3'd2,
      ALIGN    = 3'd3,
      UP       = 3'd4,
      BACKOFF  = 3'd5
   } gbt_seq_state_t;

   parameter int unsigned DEBOUNCE_CYCLES = 1024;

endpackage

// File: rtl/gbt_los_debounce.sv
// SFP loss-of-signal conditioning: 2-FF synchroniser, optionally followed by a
// stability filter (macro GBT_LINK_SEQ_LOS_DEBOUNCE_EN).
// Ports:
//   clk_i  : frame clock
//   rst_i  : synchronous active-high reset
//   los_i  : raw asynchronous SFP LOS
//   los_o  : synchronised (and, if enabled, filtered) LOS
module gbt_los_debounce
   import gbt_seq_pkg::*;
(
   input  logic clk_i,
   input  logic rst_i,
   input  logic los_i,
   output logic los_o
);

   logic sync1_q, sync2_q;

   // Reset to "signal lost" so the sequencer never leaves LOS on stale data.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         sync1_q <= 1'b1;
         sync2_q <= 1'b1;
      end else begin
         sync1_q <= los_i;
         sync2_q <= sync1_q;
      end
   end

`ifdef GBT_LINK_SEQ_LOS_DEBOUNCE_EN
   localparam int unsigned CntW = $clog2(DEBOUNCE_CYCLES);

   logic [CntW-1:0] cnt_q, cnt_d;
   logic            filt_q, filt_d;

   // Filtered value follows only after DEBOUNCE_CYCLES consecutive disagreeing samples.
   always_comb begin
      filt_d = filt_q;
      cnt_d  = '0;
      if (sync2_q != filt_q) begin
         if (cnt_q == CntW'(DEBOUNCE_CYCLES - 1)) begin
            filt_d = sync2_q;
         end else begin
            cnt_d = cnt_q + 1'b1;
         end
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         cnt_q  <= '0;
         filt_q <= 1'b1;
      end else begin
         cnt_q  <= cnt_d;
         filt_q <= filt_d;
      end
   end

   assign los_o = filt_q;
`else
   assign los_o = sync2_q;
`endif

endmodule

// File: rtl/gbt_link_sequencer.sv
// GBT optical link bring-up and supervision controller (40 MHz frame clock).
// Resets the GBT core, releases bitslip alignment, qualifies the link on
// consecutive good headers, gates TX payload and retries with backoff.
// Optional LOS stability filter: define GBT_LINK_SEQ_LOS_DEBOUNCE_EN.
// Ports:
//   ClkRs_ix         : clk / synchronous active-high reset bundle
//   sfp_los_i        : SFP loss of signal (asynchronous)
//   link_ready_i     : GBT core RX/TX ready
//   rx_frame_valid_i : one received frame this cycle
//   rx_header_ok_i   : header of current frame correct (qualified by valid)
//   gbt_reset_o      : GBT core reset, active high
//   bitslip_reset_o  : 1 = bitslip alignment released
//   tx_enable_o      : payload may be transmitted
//   link_up_o        : link qualified
//   state_o          : current state encoding
//   retry_cnt_o      : saturating count of BACKOFF entries
module gbt_link_sequencer
   import gbt_seq_pkg::*;
#(
   parameter int unsigned RESET_CYCLES   = 64,
   parameter int unsigned READY_TIMEOUT  = 4000000,
   parameter int unsigned GOOD_FRAMES    = 32,
   parameter int unsigned MAX_HDR_ERR    = 4,
   parameter int unsigned BACKOFF_CYCLES = 400000,
   parameter int unsigned RETRY_W        = 8
) (
   input  ckrs_t              ClkRs_ix,
   input  logic               sfp_los_i,
   input  logic               link_ready_i,
   input  logic               rx_frame_valid_i,
   input  logic               rx_header_ok_i,
   output logic               gbt_reset_o,
   output logic               bitslip_reset_o,
   output logic               tx_enable_o,
   output logic               link_up_o,
   output logic [2:0]         state_o,
   output logic [RETRY_W-1:0] retry_cnt_o
);

   localparam int unsigned MaxA      = (RESET_CYCLES > READY_TIMEOUT) ? RESET_CYCLES
                                                                       : READY_TIMEOUT;
   localparam int unsigned MaxCycles = (MaxA > BACKOFF_CYCLES) ? MaxA : BACKOFF_CYCLES;
   localparam int unsigned TimerW    = (MaxCycles > 2) ? $clog2(MaxCycles) : 1;
   localparam int unsigned GoodW     = $clog2(GOOD_FRAMES + 1);
   localparam int unsigned ErrW      = $clog2(MAX_HDR_ERR + 1);

   localparam logic [TimerW-1:0] RstLast  = TimerW'(RESET_CYCLES - 1);
   localparam logic [TimerW-1:0] RdyLast  = TimerW'(READY_TIMEOUT - 1);
   localparam logic [TimerW-1:0] BackLast = TimerW'(BACKOFF_CYCLES - 1);

   gbt_seq_state_t     state_q, state_d;
   logic [TimerW-1:0]  timer_q, timer_d;
   logic [GoodW-1:0]   good_q, good_d;
   logic [ErrW-1:0]    err_q, err_d;
   logic [RETRY_W-1:0] retry_q, retry_d;
   logic               gbt_reset_q, gbt_reset_d;
   logic               bitslip_q, bitslip_d;
   logic               tx_en_q, tx_en_d;
   logic               link_up_q, link_up_d;
   logic               los_filt;

   gbt_los_debounce u_los_debounce (
      .clk_i (ClkRs_ix.clk),
      .rst_i (ClkRs_ix.reset),
      .los_i (sfp_los_i),
      .los_o (los_filt)
   );

   always_comb begin
      state_d = state_q;
      timer_d = '0;
      good_d  = '0;
      err_d   = '0;
      retry_d = retry_q;

      case (state_q)
         LOS: begin
            if (!los_filt) state_d = RST;
         end
         RST: begin
            timer_d = timer_q + 1'b1;
            if (timer_q == RstLast) state_d = WAIT_RDY;
         end
         WAIT_RDY: begin
            timer_d = timer_q + 1'b1;
            if (link_ready_i)              state_d = ALIGN;
            else if (timer_q == RdyLast)   state_d = BACKOFF;
         end
         ALIGN: begin
            timer_d = timer_q + 1'b1;
            good_d  = good_q;
            if (rx_frame_valid_i) good_d = rx_header_ok_i ? good_q + 1'b1 : '0;
            // Faults win over qualification in the same cycle.
            if (!link_ready_i || timer_q == RdyLast)  state_d = BACKOFF;
            else if (good_d == GoodW'(GOOD_FRAMES))   state_d = UP;
         end
         UP: begin
            err_d = err_q;
            if (rx_frame_valid_i) err_d = rx_header_ok_i ? '0 : err_q + 1'b1;
            if (!link_ready_i || err_d == ErrW'(MAX_HDR_ERR)) state_d = BACKOFF;
         end
         BACKOFF: begin
            timer_d = timer_q + 1'b1;
            if (timer_q == BackLast) state_d = RST;
         end
         default: state_d = LOS;
      endcase

      // LOS overrides everything, so a simultaneous fault never counts as a retry.
      if (los_filt) state_d = LOS;

      if (state_d != state_q) begin
         timer_d = '0;
         good_d  = '0;
         err_d   = '0;
      end

      if (state_d == BACKOFF && state_q != BACKOFF && retry_q != {RETRY_W{1'b1}}) begin
         retry_d = retry_q + 1'b1;
      end

      gbt_reset_d = (state_d == LOS) || (state_d == RST) || (state_d == BACKOFF);
      bitslip_d   = (state_d == ALIGN) || (state_d == UP);
      tx_en_d     = (state_d == UP);
      link_up_d   = (state_d == UP);
   end

   always_ff @(posedge ClkRs_ix.clk) begin
      if (ClkRs_ix.reset) begin
         state_q     <= LOS;
         timer_q     <= '0;
         good_q      <= '0;
         err_q       <= '0;
         retry_q     <= '0;
         gbt_reset_q <= 1'b1;
         bitslip_q   <= 1'b0;
         tx_en_q     <= 1'b0;
         link_up_q   <= 1'b0;
      end else begin
         state_q     <= state_d;
         timer_q     <= timer_d;
         good_q      <= good_d;
         err_q       <= err_d;
         retry_q     <= retry_d;
         gbt_reset_q <= gbt_reset_d;
         bitslip_q   <= bitslip_d;
         tx_en_q     <= tx_en_d;
         link_up_q   <= link_up_d;
      end
   end

   assign gbt_reset_o     = gbt_reset_q;
   assign bitslip_reset_o = bitslip_q;
   assign tx_enable_o     = tx_en_q;
   assign link_up_o       = link_up_q;
   assign state_o         = state_q;
   assign retry_cnt_o     = retry_q;

endmodule
